seg_readback: RTL and testbench

Sequential checker at the far end of the adder/seven-segment path: samples the 7-bit segment bus and the carry line driven by the adder display stage and filters out transient values. It decodes each stable segment pattern back to the 4-bit nibble and reports the reconstructed 5-bit sum with a one-cycle strobe. Illegal patterns are flagged and counted. It sits beside the display driver as a self-check and readback monitor for the lab top level.

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/seg_readback_if.sv | 22 ++
 rtl/seg_pattern_decode.sv | 21 ++
 rtl/seg_readback.sv | 104 ++++++++++
 tb/tb_seg_readback.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared segment definitions for the adder display encoder and the readback checker.
// Both sides take their patterns from this table, so encoding and decoding cannot drift apart.
package seg_pkg;

    // Segment bus polarity and bit order: 0 = lit, bit 6 = a down to bit 0 = g.
    localparam bit SEG_ACTIVE_LOW = 1'b1;

    typedef enum int unsigned {
        SEG_G = 0, SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A
    } seg_bit_e;

    localparam logic [6:0] SEG_0 = 7'h01;
    localparam logic [6:0] SEG_1 = 7'h4F;
    localparam logic [6:0] SEG_2 = 7'h12;
    localparam logic [6:0] SEG_3 = 7'h06;
    localparam logic [6:0] SEG_4 = 7'h4C;
    localparam logic [6:0] SEG_5 = 7'h24;
    localparam logic [6:0] SEG_6 = 7'h20;
    localparam logic [6:0] SEG_7 = 7'h0F;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h04;
    localparam logic [6:0] SEG_A_HEX = 7'h08;
    localparam logic [6:0] SEG_B_HEX = 7'h60;
    localparam logic [6:0] SEG_C_HEX = 7'h31;
    localparam logic [6:0] SEG_D_HEX = 7'h42;
    localparam logic [6:0] SEG_E_HEX = 7'h30;
    localparam logic [6:0] SEG_F_HEX = 7'h38;

    localparam logic [6:0] SEG_TABLE [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A_HEX, SEG_B_HEX, SEG_C_HEX, SEG_D_HEX, SEG_E_HEX, SEG_F_HEX
    };

    typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg_readback_if.sv
// Segment/carry bus from the display stage plus the readback results of seg_readback.
interface seg_readback_if #(parameter int unsigned ERR_W = 8);

    logic [6:0]       seg_in;
    logic             carry_in;
    logic [4:0]       sum;
    logic             sum_valid;
    logic             seg_err;
    logic [ERR_W-1:0] err_count;
    logic             held;

    modport master (
        output seg_in, carry_in,
        input  sum, sum_valid, seg_err, err_count, held
    );

    modport slave (
        input  seg_in, carry_in,
        output sum, sum_valid, seg_err, err_count, held
    );

endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational lookup from an active-low segment pattern back to its hex digit.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b0;
        nibble = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (pattern == SEG_TABLE[i]) begin
                legal  = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_readback.sv
// Readback monitor for the segment display: debounces {carry, segments}, decodes stable
// patterns back to the 5-bit sum and counts illegal patterns.
module seg_readback
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic          clk,
    input  logic          rst,
    seg_readback_if.slave bus
);

    localparam int unsigned     RW         = $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0]   RUN_TARGET = RW'(STABLE_CYCLES);

    state_t        state, state_nxt;
    logic [7:0]    word, sample_q;
    logic [RW-1:0] run, run_inc;
    logic          match;
    logic          reload, count_up, commit;
    logic          legal_q;
    logic          pat_legal;
    logic [3:0]    pat_nibble;

    assign word    = {bus.carry_in, bus.seg_in};
    assign match   = (word == sample_q);
    assign run_inc = run + RW'(1);

    // At a commit the incoming word equals sample_q, so decoding the stored copy is enough.
    seg_pattern_decode u_decode (
        .pattern (sample_q[6:0]),
        .legal   (pat_legal),
        .nibble  (pat_nibble)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = COUNT;
            COUNT: if (match && run_inc == RUN_TARGET) state_nxt = HELD;
            HELD:  if (!match) state_nxt = COUNT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        reload   = 1'b0;
        count_up = 1'b0;
        commit   = 1'b0;
        unique case (state)
            IDLE:  reload = 1'b1;
            COUNT: begin
                if (match) begin
                    count_up = 1'b1;
                    commit   = (run_inc == RUN_TARGET);
                end else begin
                    reload = 1'b1;
                end
            end
            HELD:  reload = !match;
            default: reload = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q      <= '0;
            run           <= '0;
            legal_q       <= 1'b0;
            bus.sum       <= '0;
            bus.sum_valid <= 1'b0;
            bus.seg_err   <= 1'b0;
            bus.err_count <= '0;
        end else begin
            bus.sum_valid <= 1'b0;
            bus.seg_err   <= 1'b0;
            if (reload) begin
                sample_q <= word;
                run      <= RW'(1);
            end else if (count_up) begin
                run <= run_inc;
            end
            if (commit) begin
                legal_q <= pat_legal;
                if (pat_legal) begin
                    bus.sum       <= {sample_q[7], pat_nibble};
                    bus.sum_valid <= 1'b1;
                end else begin
                    bus.seg_err <= 1'b1;
                    if (bus.err_count != '1) bus.err_count <= bus.err_count + 1'b1;
                end
            end
        end
    end

    assign bus.held = (state == HELD) && legal_q;

endmodule

// File: tb/tb_seg_readback.sv
// Directed bench for seg_readback: expected commits are queued when a word is driven and
// matched against sum_valid/seg_err pulses, including the cycle they are due.
module tb_seg_readback;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg_readback_if #(.ERR_W(8)) bus ();

    seg_readback #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [4:0] sum;
        logic [7:0] errc;
        int         cyc;
    } exp_t;

    exp_t       sbq[$];
    int         tests = 0;
    int         fails = 0;
    int         cycle = 0;
    logic [4:0] msum  = '0;
    logic [7:0] merr  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic tick();
        exp_t e;
        bit   due;
        @(posedge clk);
        #1;
        cycle++;
        due = (sbq.size() > 0) && (sbq[0].cyc == cycle);
        check("pulse_present", 32'(bus.sum_valid | bus.seg_err), 32'(due));
        check("pulse_exclusive", 32'(bus.sum_valid & bus.seg_err), 32'd0);
        if (due) begin
            e = sbq.pop_front();
            check("pulse_is_err", 32'(bus.seg_err), 32'(e.is_err));
            check("pulse_sum", 32'(bus.sum), 32'(e.sum));
            check("pulse_err_count", 32'(bus.err_count), 32'(e.errc));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic [6:0] seg, input logic c);
        bus.seg_in   = seg;
        bus.carry_in = c;
    endtask

    // Word driven now is first sampled at the next edge and commits three edges later.
    task automatic expect_legal(input logic [4:0] s);
        exp_t e;
        msum = s;
        e = '{is_err: 1'b0, sum: s, errc: merr, cyc: cycle + 4};
        sbq.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        if (merr != 8'hFF) merr = merr + 8'd1;
        e = '{is_err: 1'b1, sum: msum, errc: merr, cyc: cycle + 4};
        sbq.push_back(e);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(7'h7F, 1'b0);
        rst = 1'b1;
        ticks(3);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        check("rst_held", 32'(bus.held), 32'd0);
        check("rst_valid", 32'(bus.sum_valid), 32'd0);

        // Digit 2, carry 0.
        rst = 1'b0;
        drive(7'h12, 1'b0);
        expect_legal(5'h02);
        ticks(4);
        check("d2_valid", 32'(bus.sum_valid), 32'd1);
        check("d2_held", 32'(bus.held), 32'd1);
        ticks(20);
        check("d2_sum_kept", 32'(bus.sum), 32'h02);
        check("d2_held_kept", 32'(bus.held), 32'd1);

        // Digit F with carry.
        drive(7'h38, 1'b1);
        tick();
        check("held_drop", 32'(bus.held), 32'd0);
        expect_legal(5'h1F);
        sbq[sbq.size()-1].cyc = cycle + 3;
        ticks(5);
        check("dF_sum", 32'(bus.sum), 32'h1F);

        // Change on the edge that would have committed 1.
        drive(7'h4F, 1'b0);
        ticks(3);
        drive(7'h06, 1'b0);
        expect_legal(5'h03);
        ticks(4);
        check("d3_valid", 32'(bus.sum_valid), 32'd1);
        check("d3_sum", 32'(bus.sum), 32'h03);
        ticks(2);

        // Illegal patterns, alternated so each one starts a fresh run.
        for (int i = 0; i < 300; i++) begin
            drive((i % 2 == 0) ? 7'h7F : 7'h7E, 1'b0);
            expect_err();
            ticks(4);
            if (i == 0) begin
                check("ill_err_count", 32'(bus.err_count), 32'd1);
                check("ill_held", 32'(bus.held), 32'd0);
                check("ill_sum_kept", 32'(bus.sum), 32'h03);
            end
        end
        check("ill_saturated", 32'(bus.err_count), 32'd255);
        check("ill_sum_after", 32'(bus.sum), 32'h03);

        // Carry alone restarts the run; returning to the old word commits again.
        drive(7'h00, 1'b0);
        expect_legal(5'h08);
        ticks(4);
        drive(7'h00, 1'b1);
        expect_legal(5'h18);
        ticks(4);
        check("carry_sum", 32'(bus.sum), 32'h18);
        drive(7'h00, 1'b0);
        expect_legal(5'h08);
        ticks(4);
        check("return_sum", 32'(bus.sum), 32'h08);

        // Reset at run = 3 discards the pending commit.
        drive(7'h24, 1'b0);
        ticks(3);
        rst = 1'b1;
        msum = '0;
        merr = '0;
        tick();
        check("mrst_sum", 32'(bus.sum), 32'd0);
        check("mrst_err_count", 32'(bus.err_count), 32'd0);
        check("mrst_valid", 32'(bus.sum_valid), 32'd0);
        check("mrst_held", 32'(bus.held), 32'd0);
        rst = 1'b0;
        expect_legal(5'h05);
        ticks(4);
        check("d5_sum", 32'(bus.sum), 32'h05);
        check("d5_held", 32'(bus.held), 32'd1);
        ticks(3);
        check("queue_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
